// File: rtl/dac_serial_tx_if.sv
`default_nettype none
// dac_serial_tx_if: start/busy/done handshake and channel words for dac_serial_tx.
// Rev 1.0
interface dac_serial_tx_if #(
  parameter int DATA_W = 12,
  parameter int CMD_W  = 4,
  parameter int N_CH   = 2
);
  logic                   start;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH*CMD_W-1:0]  ch_cmd;
  logic                   busy;
  logic                   done;

  modport master (output start, ch_data, ch_cmd, input busy, done);
  modport slave  (input start, ch_data, ch_cmd, output busy, done);
endinterface
`default_nettype wire

// File: rtl/dac_serial_tx.sv
`default_nettype none
// dac_serial_tx: self-clocked serial DAC transmitter sending N_CH {cmd,data} frames per start.
// Rev 1.0
module dac_serial_tx #(
  parameter int DATA_W    = 12,
  parameter int FRAME_W   = 16,
  parameter int N_CH      = 2,
  parameter int CLK_DIV   = 4,
  parameter int GAP_TICKS = 2,
  parameter int MSB_FIRST = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  dac_serial_tx_if.slave ctl,
  output logic           sclk,
  output logic           sync_n,
  output logic           sdata
);
  localparam int CMD_W = FRAME_W - DATA_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [DIV_W-1:0]       div_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [CH_W-1:0]        ch_idx, idx_inc;
  logic [N_CH*DATA_W-1:0] sh_data;
  logic [N_CH*CMD_W-1:0]  sh_cmd;
  logic [FRAME_W-1:0]     frm, frm_nxt;
  logic                   tick;

  function automatic logic first_bit(input logic [FRAME_W-1:0] f);
    return (MSB_FIRST != 0) ? f[FRAME_W-1] : f[0];
  endfunction

  assign tick    = (state != S_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign idx_inc = ch_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    frm_nxt   = frm;
    case (state)
      S_IDLE: begin
        if (ctl.start) begin
          state_nxt = S_LOAD;
          frm_nxt   = {ctl.ch_cmd[CMD_W-1:0], ctl.ch_data[DATA_W-1:0]};
        end
      end
      S_LOAD: begin
        if (tick) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // Rising sclk toggle: either move to the next bit or finish the frame
        if (tick && !sclk) begin
          if (bit_cnt == BIT_W'(FRAME_W)) state_nxt = S_GAP;
          else if (MSB_FIRST != 0)        frm_nxt = {frm[FRAME_W-2:0], 1'b0};
          else                            frm_nxt = {1'b0, frm[FRAME_W-1:1]};
        end
      end
      S_GAP: begin
        if (tick && gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
          if (int'(ch_idx) < N_CH - 1) begin
            state_nxt = S_LOAD;
            frm_nxt   = {sh_cmd[int'(idx_inc)*CMD_W +: CMD_W],
                         sh_data[int'(idx_inc)*DATA_W +: DATA_W]};
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      ch_idx    <= '0;
      sh_data   <= '0;
      sh_cmd    <= '0;
      frm       <= '0;
      sclk      <= 1'b1;
      sync_n    <= 1'b1;
      sdata     <= 1'b0;
      ctl.busy  <= 1'b0;
      ctl.done  <= 1'b0;
    end else begin
      state <= state_nxt;
      frm   <= frm_nxt;

      div_cnt <= (state == S_IDLE || tick) ? '0 : div_cnt + 1'b1;

      if (state == S_IDLE && ctl.start) begin
        sh_data <= ctl.ch_data;
        sh_cmd  <= ctl.ch_cmd;
      end

      if (state_nxt == S_LOAD)                bit_cnt <= '0;
      else if (state == S_SHIFT && tick && sclk) bit_cnt <= bit_cnt + 1'b1;

      if (state != S_GAP) gap_cnt <= '0;
      else if (tick)      gap_cnt <= gap_cnt + 1'b1;

      if (state == S_GAP && state_nxt == S_LOAD)    ch_idx <= idx_inc;
      else if (state == S_DONE || state == S_IDLE) ch_idx <= '0;

      if (state != S_SHIFT) sclk <= 1'b1;
      else if (tick)        sclk <= ~sclk;

      // Outputs are registered from the next state so they never glitch
      sync_n   <= !(state_nxt == S_LOAD || state_nxt == S_SHIFT);
      sdata    <= (state_nxt == S_LOAD || state_nxt == S_SHIFT) ? first_bit(frm_nxt) : 1'b0;
      ctl.busy <= (state_nxt == S_LOAD || state_nxt == S_SHIFT || state_nxt == S_GAP);
      ctl.done <= (state_nxt == S_DONE);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dac_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_dac_serial_tx: scoreboard bench; instance 0 N_CH=1, 1 N_CH=2, 2 CLK_DIV=1 LSB-first.
// Rev 1.0
module tb_dac_serial_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  wire  [2:0] sclk_w, sync_w, sdata_w, busy_w, done_w;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dac_serial_tx_if #(.DATA_W(12), .CMD_W(4), .N_CH(1)) ifa ();
  dac_serial_tx_if #(.DATA_W(12), .CMD_W(4), .N_CH(2)) ifb ();
  dac_serial_tx_if #(.DATA_W(12), .CMD_W(4), .N_CH(1)) ifc ();

  assign ifa.start = start_v[0];
  assign ifb.start = start_v[1];
  assign ifc.start = start_v[2];
  assign busy_w = {ifc.busy, ifb.busy, ifa.busy};
  assign done_w = {ifc.done, ifb.done, ifa.done};

  dac_serial_tx #(.N_CH(1)) dut_a (
    .clk(clk), .rst(rst), .ctl(ifa),
    .sclk(sclk_w[0]), .sync_n(sync_w[0]), .sdata(sdata_w[0]));
  dac_serial_tx #(.N_CH(2)) dut_b (
    .clk(clk), .rst(rst), .ctl(ifb),
    .sclk(sclk_w[1]), .sync_n(sync_w[1]), .sdata(sdata_w[1]));
  dac_serial_tx #(.N_CH(1), .CLK_DIV(1), .MSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .ctl(ifc),
    .sclk(sclk_w[2]), .sync_n(sync_w[2]), .sdata(sdata_w[2]));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor: collects bits at sclk falls while sync_n is low, checks against queue
  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    localparam int CD = (gi == 2) ? 1 : 4;
    logic [15:0] exp_q[$];
    logic [15:0] word = '0;
    int nbits = 0, low_cnt = 0, high_cnt = 0, since_fall = 0, done_cnt = 0;
    bit prev_sclk = 1'b1, prev_sync = 1'b1, in_gap = 1'b0, per_bad = 1'b0;

    always @(negedge clk) begin
      if (rst) begin
        nbits = 0; low_cnt = 0; high_cnt = 0; in_gap = 1'b0;
        prev_sclk = 1'b1; prev_sync = 1'b1;
      end else begin
        if (done_w[gi]) begin
          done_cnt++;
          in_gap = 1'b0;
        end
        if (!sync_w[gi]) begin
          if (prev_sync) begin
            if (in_gap) check($sformatf("gap_len%0d", gi), high_cnt, 2 * CD);
            nbits = 0; low_cnt = 0; word = '0; per_bad = 1'b0; since_fall = 0;
          end
          low_cnt++;
          since_fall++;
          if (prev_sclk && !sclk_w[gi]) begin
            if (nbits > 0 && since_fall != 2 * CD) per_bad = 1'b1;
            word = {word[14:0], sdata_w[gi]};
            nbits++;
            since_fall = 0;
          end
        end else begin
          if (!prev_sync) begin
            check($sformatf("bits%0d", gi), nbits, 16);
            check($sformatf("sync_low%0d", gi), low_cnt, 33 * CD);
            check($sformatf("sclk_period%0d", gi), int'(per_bad), 0);
            if (exp_q.size() == 0) check($sformatf("exp_avail%0d", gi), 0, 1);
            else check($sformatf("word%0d", gi), int'(word), int'(exp_q.pop_front()));
            in_gap = busy_w[gi];
            high_cnt = 0;
          end
          high_cnt++;
        end
        prev_sync = sync_w[gi];
        prev_sclk = sclk_w[gi];
      end
    end
  end

  task automatic start_xfer(input int idx);
    @(posedge clk); #1 start_v[idx] = 1'b1;
    @(posedge clk); #1 start_v[idx] = 1'b0;
    @(negedge clk);
    check($sformatf("sync_fall_lat%0d", idx), int'(sync_w[idx]), 0);
  endtask

  task automatic wait_done(input int idx, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_w[idx] && n < limit);
    check($sformatf("done_seen%0d", idx), int'(done_w[idx]), 1);
  endtask

  initial begin
    int n;
    ifa.ch_cmd = '0; ifa.ch_data = '0;
    ifb.ch_cmd = '0; ifb.ch_data = '0;
    ifc.ch_cmd = '0; ifc.ch_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", int'({sclk_w, sync_w, sdata_w, busy_w, done_w}),
          int'(15'b111_111_000_000_000));
    @(posedge clk); #1 rst = 1'b0;

    // Single frame 0x3ABC, MSB first
    ifa.ch_cmd = 4'h3; ifa.ch_data = 12'hABC;
    g_mon[0].exp_q.push_back(16'h3ABC);
    start_xfer(0);
    check("busy_a", int'(busy_w[0]), 1);
    wait_done(0, 400, n);
    check("done_time_a", n, 140);
    @(negedge clk);
    check("done_pulse_a", int'({done_w[0], busy_w[0]}), 0);

    // Two channels, with an ignored mid-frame start and input change
    ifb.ch_cmd = {4'h9, 4'h1}; ifb.ch_data = {12'hFFF, 12'h000};
    g_mon[1].exp_q.push_back(16'h1000);
    g_mon[1].exp_q.push_back(16'h9FFF);
    start_xfer(1);
    repeat (40) @(posedge clk);
    #1 ifb.ch_data = 24'h555555; ifb.ch_cmd = 8'h77; start_v[1] = 1'b1;
    @(posedge clk); #1 start_v[1] = 1'b0;
    @(negedge clk);
    check("busy_after_extra_start", int'(busy_w[1]), 1);
    wait_done(1, 600, n);
    repeat (300) @(negedge clk);
    check("done_count_b", g_mon[1].done_cnt, 1);
    check("idle_b", int'({busy_w[1], sync_w[1]}), 1);

    // Reset during bit 7 of frame 0, then a clean frame
    start_xfer(0);
    repeat (62) @(posedge clk);
    #1 check("pre_rst_active", int'({busy_w[0], sync_w[0]}), 2);
    rst = 1'b1;
    #1 check("rst_outs_a", int'({sclk_w[0], sync_w[0], sdata_w[0], busy_w[0], done_w[0]}), 5'b11000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("no_done_on_abort", g_mon[0].done_cnt, 1);
    g_mon[0].exp_q.push_back(16'h3ABC);
    start_xfer(0);
    wait_done(0, 400, n);
    check("done_time_a2", n, 140);

    // CLK_DIV=1, LSB first: sampled order is the bit-reversed frame
    ifc.ch_cmd = 4'h0; ifc.ch_data = 12'h001;
    g_mon[2].exp_q.push_back(16'h8000);
    start_xfer(2);
    wait_done(2, 200, n);
    check("done_time_c", n, 35);
    ifc.ch_cmd = 4'hA; ifc.ch_data = 12'h0F0;
    g_mon[2].exp_q.push_back(16'h0F05);
    start_xfer(2);
    wait_done(2, 200, n);
    check("done_time_c2", n, 35);

    // Start held high: back-to-back transfers restart 2 clk after done
    g_mon[0].exp_q.push_back(16'h3ABC);
    g_mon[0].exp_q.push_back(16'h3ABC);
    @(posedge clk); #1 start_v[0] = 1'b1;
    wait_done(0, 400, n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sync_w[0] && n < 10);
    check("retrigger_gap", n, 2);
    wait_done(0, 400, n);
    start_v[0] = 1'b0;

    repeat (50) @(negedge clk);
    check("q_empty_a", g_mon[0].exp_q.size(), 0);
    check("q_empty_b", g_mon[1].exp_q.size(), 0);
    check("q_empty_c", g_mon[2].exp_q.size(), 0);
    check("done_count_a", g_mon[0].done_cnt, 4);
    check("done_count_c", g_mon[2].done_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dac_serial_tx.md
Name: dac_serial_tx

Overview:
- Parametrised serial DAC transmitter that generates its own sclk, an active-low frame sync (sync_n) and sdata.
- Takes N_CH channel words plus a per-channel command prefix and sends them as consecutive frames of FRAME_W bits.
- Uses a start/busy/done handshake toward the control FSM.
- Replaces fixed 16-bit, externally-clocked shift registers in the DAC output path; runs entirely on the system clock.

Parameters:
- DATA_W, 12: data bits per channel.
- FRAME_W, 16: bits per frame. Must satisfy FRAME_W > DATA_W. CMD_W = FRAME_W-DATA_W.
- N_CH, 2: channels sent per start, minimum 1.
- CLK_DIV, 4: clk cycles per sclk half-period (one "tick"), minimum 1.
- GAP_TICKS, 2: ticks with sync_n high between frames, minimum 1.
- MSB_FIRST, 1: 1 sends frame bit FRAME_W-1 first; 0 sends bit 0 first.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: request a transfer. Sampled only in IDLE.
- ch_data, input, N_CH*DATA_W: channel k occupies [k*DATA_W +: DATA_W].
- ch_cmd, input, N_CH*CMD_W: channel k prefix occupies [k*CMD_W +: CMD_W].
- busy, output, 1: high from the cycle after start is accepted until DONE.
- done, output, 1: one-clk pulse after the last frame.
- sclk, output, 1: serial clock, idles high.
- sync_n, output, 1: low during each frame.
- sdata, output, 1: serial data. Changes on sclk rising edges only; the DAC samples it on falling edges.

Behaviour:
- Reset (async) values: busy=0, done=0, sclk=1, sync_n=1, sdata=0, state=IDLE, all counters 0.
- Reset mid-transfer aborts immediately; no partial done.
- Frame k = {ch_cmd[k], ch_data[k]}, CMD_W MSBs then DATA_W LSBs.
- Channels are sent in order k=0..N_CH-1.
- Capture: a start in IDLE latches ch_data and ch_cmd into shadow registers on the same edge. Inputs may change afterwards without effect.
- Tick generator:
  - div_cnt counts 0..CLK_DIV-1 whenever state != IDLE and wraps.
  - tick = (div_cnt == CLK_DIV-1).
  - div_cnt is cleared on entry from IDLE.
- State IDLE: outputs idle. On start go to LOAD. busy=1 from the next cycle.
- State LOAD (1 tick):
  - sync_n=0, sclk=1.
  - sdata = first bit of frame ch_idx, driven from LOAD entry.
  - On tick go to SHIFT.
- State SHIFT (2*FRAME_W ticks): each tick toggles sclk.
  - Falling toggle (1->0): bit_cnt++. The DAC samples here.
  - Rising toggle (0->1): if bit_cnt < FRAME_W, shift the next bit onto sdata. After the final bit, sdata holds its value.
  - After tick 2*FRAME_W, sclk is high and bit_cnt == FRAME_W; go to GAP.
- State GAP (GAP_TICKS ticks):
  - sync_n=1, sclk=1, sdata=0.
  - On the last tick: if ch_idx < N_CH-1, increment ch_idx and go to LOAD; otherwise go to DONE.
- State DONE (1 clk): done=1, busy=0 in the same cycle, ch_idx=0. Next cycle go to IDLE.
- Handshake:
  - start while busy or in DONE is ignored, not queued.
  - A start held high continuously re-triggers in the first IDLE cycle after DONE.
- Timing per frame: (1 + 2*FRAME_W + GAP_TICKS)*CLK_DIV clk. Defaults give 35 ticks = 140 clk.
- Latency: start accepted to first sync_n fall is 1 clk. Total transfer time is N_CH frames plus the 1-clk DONE.
- CLK_DIV=1: tick every cycle, so sclk = clk/2. Same state sequence.
- N_CH=1: no second LOAD; goes GAP to DONE.
- Bit order: MSB_FIRST=0 sends frame bit 0 first. The cmd field is then sent last, with no other change.

Test Plan:
- Defaults, N_CH=1, cmd=4'h3, data=12'hABC, start pulse -> sync_n low for 33 ticks. 16 falling edges sample 0011_1010_1011_1100. sync_n rises 132 clk after falling. done pulses once, at 140 clk + 1 after start.
- N_CH=2, ch0={4'h1,12'h000}, ch1={4'h9,12'hFFF} -> two frames separated by exactly 2 ticks (8 clk) of sync_n high. Samples are 0x1000 then 0x9FFF. One done only.
- Change ch_data and pulse start again mid-frame 0 -> the transfer still sends the captured values. The extra start is ignored; busy stays 1 and there is no second transfer.
- Assert rst at bit 7 of frame 0 -> the same cycle shows sclk=1, sync_n=1, sdata=0, busy=0, done=0. A new start after release sends a full frame from bit 15.
- CLK_DIV=1, MSB_FIRST=0, data=12'h001, cmd=0 -> sclk period 2 clk. First sampled bit is 1, followed by 15 zeros.
- Hold start high continuously, N_CH=1 -> back-to-back transfers. Each new sync_n fall occurs 2 clk after the previous done.
